imm_encoder: RTL
================

Name: imm_encoder

Overview:
- Inverse of the immediate sign-extend decoder: packs a 32-bit immediate into the correct bit positions of an RV32I instruction template.
- Checks that the immediate is representable in the selected format.
- Feeds the self-test instruction generator and the boot-ROM patcher.
- Two-stage valid/ready pipeline with full throughput and an error-count side output.

Parameters:
- DATA_WIDTH, 32, instruction and immediate width (only 32 supported).
- ERR_CNT_WIDTH, 16, width of the saturating error counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  request accepted when in_valid_i && in_ready_o.
- imm_src_i  in  3  format: 000 I, 001 B, 010 S, 011 U, 100 J; others illegal.
- imm_i  in  DATA_WIDTH  immediate value (byte offset for B/J, full value for U).
- instr_i  in  DATA_WIDTH  template; non-immediate bits pass through.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer ready.
- instr_o  out  DATA_WIDTH  encoded instruction.
- err_code_o  out  2  00 ok, 01 range, 10 alignment/low-bits, 11 illegal imm_src.
- err_cnt_o  out  ERR_CNT_WIDTH  count of errored results delivered; saturates.

Behaviour:
- Reset: out_valid_o=0, instr_o=0, err_code_o=00, err_cnt_o=0, both stages invalid, in_ready_o=1. Reset mid-operation discards in-flight data with no output.
- S1 registers the inputs. S2 registers the encoded result, err_code and valid.
- Latency: 2 cycles from accept to out_valid_o with no stall. Throughput: 1 per cycle.
- S2 can load when !s2_valid || out_ready_i.
- S1 advances into S2 whenever S2 can load.
- in_ready_o = !s1_valid || S2 can load. It is combinational from out_ready_i, with no path from in_valid_i.
- Stall: while out_valid_o && !out_ready_i, instr_o and err_code_o hold stable. Order is preserved and nothing is dropped or duplicated.
- Encoding (bits not listed come from instr_i):
  - I: [31:20]=imm[11:0]
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]
  - U: [31:12]=imm[31:12]
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1]
- Checks, priority illegal > alignment > range:
  - I/S: imm[31:11] all equal, else 01.
  - B: imm[0]==0, else 10; imm[31:12] all equal, else 01.
  - J: imm[0]==0, else 10; imm[31:20] all equal, else 01.
  - U: imm[11:0]==0, else 10.
- On any error: immediate bit positions of the format are forced to 0; other template bits pass through. Illegal src passes instr_i unchanged.
- err_cnt_o increments on out_valid_o && out_ready_i && err_code_o!=00. It holds at all-ones.

Optional Feature:
- IMM_ENC_ROUNDTRIP_CHECK_EN defined:
  - Adds output rt_fail_o (1 bit, reset 0).
  - S2 result is re-decoded by an internal decoder (same format rules as the sign-extend decoder) and compared to the stored imm for err_code_o==00 entries.
  - Mismatch sets rt_fail_o sticky until reset; a simulation assertion fires.
- Undefined: no port, no logic.

Decomposition:
- imm_enc_pkg:
  - imm_src_e enum (IMM_I=3'b000, IMM_B=3'b001, IMM_S=3'b010, IMM_U=3'b011, IMM_J=3'b100), identical to decoder encoding.
  - imm_err_e enum (ERR_NONE, ERR_RANGE, ERR_ALIGN, ERR_SRC).
  - s1 payload struct.
- Sub-module imm_enc_pack: purely combinational scatter plus range/alignment check, instantiated between S1 and S2. The top holds the pipeline registers, handshake and counter.

Test Plan:
- I, imm=0xFFFFFFFF, instr=0x00000013, out_ready_i=1 -> instr_o=0xFFF00013, err 00, valid 2 cycles after accept.
- S imm=8, instr=0x00002023 -> 0x00002423. B imm=0xFFFFFFFC, instr=0x00000063 -> 0xFE000EE3. J imm=0x800, instr=0x0000006F -> 0x0010006F.
- Errors:
  - B imm=3, instr=0x00000063 -> 0x00000063, err 10.
  - I imm=2048 -> err 01.
  - imm_src=101, instr=0x12345678 -> 0x12345678, err 11; err_cnt_o=3 after all three consumed.
- Backpressure: out_ready_i=0, in_valid_i=1 with 4 back-to-back requests -> 2 accepted, in_ready_o=0. Then out_ready_i=1 -> all 4 emerge in order, one per cycle, none lost.
- Reset pulse with both stages full and out_ready_i=0 -> out_valid_o=0 immediately (async), err_cnt_o=0, in_ready_o=1 after release.
- Counter: force 0xFFFE then deliver 3 errored results -> err_cnt_o=0xFFFF, no wrap. With IMM_ENC_ROUNDTRIP_CHECK_EN, 1000 random legal inputs -> rt_fail_o stays 0.

Source files
------------

// File: rtl/imm_enc_pkg.sv
// Shared types and helpers for the RV32I immediate encoder.
// Format and error encodings are identical to those of the sign-extend decoder.
package imm_enc_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_B = 3'b001,
        IMM_S = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_RANGE = 2'b01,
        ERR_ALIGN = 2'b10,
        ERR_SRC   = 2'b11
    } imm_err_e;

    // Stage-1 payload; imm_src is kept raw so illegal codes survive to the check
    typedef struct packed {
        logic [2:0]      imm_src;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] instr;
    } s1_payload_t;

    // True when v[XLEN-1:lsb] are all equal, i.e. v fits as a sign-extended field
    function automatic logic upper_uniform(input logic [XLEN-1:0] v, input int unsigned lsb);
        logic [XLEN-1:0] sh;
        sh = $signed(v) >>> lsb;
        return (sh == '0) || (sh == '1);
    endfunction

    // Reference sign-extend decoder, used to re-derive the immediate from an encoding
    function automatic logic [XLEN-1:0] decode_imm(input logic [2:0] src, input logic [XLEN-1:0] ins);
        logic [XLEN-1:0] r;
        case (src)
            IMM_I:   r = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   r = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   r = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   r = {ins[31:12], 12'b0};
            IMM_J:   r = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imm_enc_pack.sv
// Combinational scatter of an immediate into an RV32I template, plus the
// representability check (illegal source > alignment > range).
module imm_enc_pack
    import imm_enc_pkg::*;
(
    input  logic [2:0]      imm_src_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] instr_i,
    output logic [XLEN-1:0] instr_o,
    output logic [1:0]      err_o
);

    logic [XLEN-1:0] field_mask;
    logic [XLEN-1:0] placed;
    imm_err_e        err;

    // Select field mask, placed immediate bits and error code for the format
    always_comb begin
        field_mask = '0;
        placed     = '0;
        err        = ERR_NONE;
        case (imm_src_i)
            IMM_I: begin
                field_mask = 32'hFFF0_0000;
                placed     = {imm_i[11:0], 20'b0};
                if (!upper_uniform(imm_i, 11)) err = ERR_RANGE;
            end
            IMM_S: begin
                field_mask = 32'hFE00_0F80;
                placed     = {imm_i[11:5], 13'b0, imm_i[4:0], 7'b0};
                if (!upper_uniform(imm_i, 11)) err = ERR_RANGE;
            end
            IMM_B: begin
                field_mask = 32'hFE00_0F80;
                placed     = {imm_i[12], imm_i[10:5], 13'b0, imm_i[4:1], imm_i[11], 7'b0};
                if (imm_i[0])                       err = ERR_ALIGN;
                else if (!upper_uniform(imm_i, 12)) err = ERR_RANGE;
            end
            IMM_U: begin
                field_mask = 32'hFFFF_F000;
                placed     = {imm_i[31:12], 12'b0};
                if (imm_i[11:0] != 12'b0) err = ERR_ALIGN;
            end
            IMM_J: begin
                field_mask = 32'hFFFF_F000;
                placed     = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'b0};
                if (imm_i[0])                       err = ERR_ALIGN;
                else if (!upper_uniform(imm_i, 20)) err = ERR_RANGE;
            end
            default: begin
                // Illegal source: no field is touched, template passes unchanged
                err = ERR_SRC;
            end
        endcase
    end

    // Errored results zero the immediate field; other template bits pass through
    always_comb begin
        instr_o = (instr_i & ~field_mask) | ((err == ERR_NONE) ? placed : '0);
        err_o   = err;
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready RV32I immediate encoder with saturating error counter.
// Optional round-trip self-check enabled by defining IMM_ENC_ROUNDTRIP_CHECK_EN
// (adds rt_fail_o); without the macro there is no extra port or logic.
module imm_encoder
    import imm_enc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [2:0]               imm_src_i,
    input  logic [DATA_WIDTH-1:0]    imm_i,
    input  logic [DATA_WIDTH-1:0]    instr_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DATA_WIDTH-1:0]    instr_o,
    output logic [1:0]               err_code_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
    ,
    output logic                     rt_fail_o
`endif
);

    logic                     s1_valid_q, s1_valid_d;
    s1_payload_t              s1_q, s1_d;
    logic                     s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0]    instr_q, instr_d;
    logic [1:0]               err_q, err_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    logic                     s2_load;
    logic                     accept;
    logic [DATA_WIDTH-1:0]    pack_instr;
    logic [1:0]               pack_err;

`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
    logic [2:0]               s2_src_q, s2_src_d;
    logic [DATA_WIDTH-1:0]    s2_imm_q, s2_imm_d;
    logic                     rt_fail_q, rt_fail_d;
    logic                     rt_mismatch;
`endif

    imm_enc_pack u_pack (
        .imm_src_i (s1_q.imm_src),
        .imm_i     (s1_q.imm),
        .instr_i   (s1_q.instr),
        .instr_o   (pack_instr),
        .err_o     (pack_err)
    );

    // Handshake: in_ready depends only on stage state and out_ready_i
    always_comb begin
        s2_load    = !s2_valid_q || out_ready_i;
        in_ready_o = !s1_valid_q || s2_load;
        accept     = in_valid_i && in_ready_o;
    end

    // Stage 1 captures the request; it empties into S2 whenever S2 can load
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (in_ready_o) s1_valid_d = in_valid_i;
        if (accept) begin
            s1_d.imm_src = imm_src_i;
            s1_d.imm     = imm_i;
            s1_d.instr   = instr_i;
        end
    end

    // Stage 2 holds the encoded result; data only changes when a new item lands
    always_comb begin
        s2_valid_d = s2_valid_q;
        instr_d    = instr_q;
        err_d      = err_q;
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
        s2_src_d   = s2_src_q;
        s2_imm_d   = s2_imm_q;
`endif
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                instr_d  = pack_instr;
                err_d    = pack_err;
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
                s2_src_d = s1_q.imm_src;
                s2_imm_d = s1_q.imm;
`endif
            end
        end
    end

    // Count errored results as they are consumed, saturating at all-ones
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (s2_valid_q && out_ready_i && (err_q != ERR_NONE) && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end

`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
    // Re-decode clean results and flag any disagreement with the original immediate
    always_comb begin
        rt_mismatch = s2_valid_q && (err_q == ERR_NONE) &&
                      (decode_imm(s2_src_q, instr_q) != s2_imm_q);
        rt_fail_d   = rt_fail_q | rt_mismatch;
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) !rt_mismatch);

    assign rt_fail_o = rt_fail_q;
`endif

    // Pipeline, counter and sticky-flag registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            instr_q    <= '0;
            err_q      <= ERR_NONE;
            err_cnt_q  <= '0;
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
            s2_src_q   <= '0;
            s2_imm_q   <= '0;
            rt_fail_q  <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            instr_q    <= instr_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
            s2_src_q   <= s2_src_d;
            s2_imm_q   <= s2_imm_d;
            rt_fail_q  <= rt_fail_d;
`endif
        end
    end

    assign out_valid_o = s2_valid_q;
    assign instr_o     = instr_q;
    assign err_code_o  = err_q;
    assign err_cnt_o   = err_cnt_q;

endmodule
